// File: rtl/sha256_block_packer.sv
// sha256_block_packer: packs a byte stream into padded 512-bit SHA-256 blocks with a big-endian bit-length trailer.
module sha256_block_packer #(
   parameter int IN_BYTES = 1,
   parameter int LEN_W    = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [8*IN_BYTES-1:0]         data_in,
   input  logic [$clog2(IN_BYTES+1)-1:0] data_nbytes,
   input  logic                          data_valid,
   input  logic                          data_last,
   output logic                          data_ready,
   output logic [511:0]                  block_out,
   output logic                          block_valid,
   input  logic                          block_ready,
   output logic                          block_last
);
   typedef enum logic [2:0] {FILL, EMIT_DATA, PAD, EMIT_PAD, LEN_BLK, EMIT_FINAL} state_t;
   state_t state_q, state_d;
   logic [511:0] buf_q, buf_d, beat_bits;
   logic [6:0] ptr_q, ptr_d, n, ptr_nx;
   logic [LEN_W-1:0] len_q, len_d;
   logic [63:0] len_field;
   logic ended_q, ended_d, live_q, take, emit_hs;

   assign n = data_last ? 7'(data_nbytes) : 7'(IN_BYTES);
   assign ptr_nx = ptr_q + n;
   assign take = data_valid && data_ready;
   assign emit_hs = block_valid && block_ready;
   assign len_field = 64'(len_q);
   // keep only the beat's valid leading bytes, then slide them down to ptr
   assign beat_bits = ({data_in, {(512-8*IN_BYTES){1'b0}}} & ~({512{1'b1}} >> {n, 3'b000})) >> {ptr_q, 3'b000};

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= FILL;
      else state_q <= state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL:       if (take && (data_last || ptr_nx == 7'd64)) state_d = ptr_nx == 7'd64 ? EMIT_DATA : PAD;
         EMIT_DATA:  if (emit_hs) state_d = ended_q ? PAD : FILL;
         PAD:        state_d = ptr_q <= 7'd55 ? EMIT_FINAL : EMIT_PAD;
         EMIT_PAD:   if (emit_hs) state_d = LEN_BLK;
         LEN_BLK:    state_d = EMIT_FINAL;
         EMIT_FINAL: if (emit_hs) state_d = FILL;
         default:    state_d = FILL;
      endcase
   end

   always_comb begin
      data_ready = live_q && state_q == FILL;
      block_valid = state_q inside {EMIT_DATA, EMIT_PAD, EMIT_FINAL};
      block_last = state_q == EMIT_FINAL;
      block_out = buf_q;
   end

   always_comb begin
      buf_d = buf_q;
      ptr_d = ptr_q;
      len_d = len_q;
      ended_d = ended_q;
      case (state_q)
         FILL: if (take) begin
            buf_d = buf_q | beat_bits;
            ptr_d = ptr_nx;
            len_d = len_q + LEN_W'({n, 3'b000});
            ended_d = data_last;
         end
         PAD: begin
            buf_d = buf_q | ({8'h80, 504'd0} >> {ptr_q, 3'b000});
            if (ptr_q <= 7'd55) buf_d[63:0] = len_field;
         end
         EMIT_DATA: if (emit_hs) begin
            buf_d = '0;
            ptr_d = '0;
         end
         EMIT_PAD: if (emit_hs) buf_d = '0;
         LEN_BLK: buf_d[63:0] = len_field;
         EMIT_FINAL: if (emit_hs) begin
            buf_d = '0;
            ptr_d = '0;
            len_d = '0;
            ended_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         buf_q <= '0;
         ptr_q <= '0;
         len_q <= '0;
         ended_q <= 1'b0;
         live_q <= 1'b0;
      end else begin
         buf_q <= buf_d;
         ptr_q <= ptr_d;
         len_q <= len_d;
         ended_q <= ended_d;
         live_q <= 1'b1;
      end
endmodule

// File: doc/sha256_block_packer.md
SHA256_BLOCK_PACKER -- requirements
Module: sha256_block_packer

Interface
REQ-001 SHALL have parameter IN_BYTES, default 1, meaning bytes per input beat; legal values 1, 2, 4.
REQ-002 SHALL have parameter LEN_W, default 64, meaning bit-length counter width; legal range 16..64.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port data_in, input, 8*IN_BYTES, message bytes; first byte is in the MSBs.
REQ-006 SHALL have port data_nbytes, input, $clog2(IN_BYTES+1), count of valid leading bytes; honoured only when data_last=1, otherwise treated as IN_BYTES.
REQ-007 SHALL have port data_valid, input, 1, input beat valid.
REQ-008 SHALL have port data_last, input, 1, final beat of message, qualified by data_valid.
REQ-009 SHALL have port data_ready, output, 1, packer can accept a beat.
REQ-010 SHALL have port block_out, output, 512, padded block; byte 0 is in [511:504].
REQ-011 SHALL have port block_valid, output, 1, block_out holds a complete block.
REQ-012 SHALL have port block_ready, input, 1, consumer accepts the block.
REQ-013 SHALL have port block_last, output, 1, block is the final block of the message (it carries the length field).

Function
REQ-014 SHALL transfer a beat when data_valid&&data_ready, and a block when block_valid&&block_ready, both on the clock edge.
REQ-015 SHALL hold a 512-bit buffer and a byte pointer ptr (0..64); an accepted beat writes its valid bytes at ptr..ptr+n-1 and advances ptr by n.
REQ-016 SHALL add 8*n to the bit-length counter per accepted beat, modulo 2^LEN_W.
REQ-017 SHALL use the FSM states FILL, EMIT_DATA, PAD, EMIT_PAD, LEN_BLK, EMIT_FINAL.
REQ-018 SHALL assert data_ready only in FILL.
REQ-019 SHALL assert block_valid only in the EMIT_* states.
REQ-020 FILL: on a non-last beat that brings ptr to 64, SHALL go to EMIT_DATA.
REQ-021 FILL: on a last beat, SHALL go to EMIT_DATA if ptr becomes 64, else to PAD.
REQ-022 EMIT_DATA: block_last=0; on handshake, SHALL clear the buffer, set ptr=0, and go to FILL, or to PAD if the message has ended.
REQ-023 PAD: SHALL write 0x80 at ptr, then go to EMIT_FINAL with the length inserted if ptr<=55, else to EMIT_PAD.
REQ-024 EMIT_PAD: block_last=0; on handshake, SHALL clear the buffer and go to LEN_BLK.
REQ-025 LEN_BLK: SHALL insert the length and go to EMIT_FINAL.
REQ-026 Length insertion SHALL write bytes 56..63 (block_out[63:0]) with the zero-extended bit counter, big-endian.
REQ-027 EMIT_FINAL: block_last=1; on handshake, SHALL clear the buffer, ptr and counter and go to FILL.
REQ-028 Unwritten buffer bytes SHALL be zero.
REQ-029 block_out and block_last SHALL be stable while block_valid=1 and block_ready=0.
REQ-030 SHALL add 2 cycles of latency from acceptance of a last beat with ptr<=55 to block_valid.
REQ-031 SHALL add 1 cycle of latency from acceptance of a beat that fills ptr to 64 to block_valid.
REQ-032 A last beat with data_nbytes=0 SHALL terminate the message without adding data (empty-message support).
REQ-033 Non-last beats SHALL always be full; IN_BYTES divides 64, so a beat never straddles blocks.
REQ-034 block_ready asserted outside EMIT_* states SHALL be ignored.

Reset
REQ-035 rst_n=0 SHALL immediately force state FILL, ptr=0, counter=0, buffer=0, block_valid=0, block_last=0, data_ready=0.
REQ-036 data_ready SHALL rise on the first clock after rst_n release.
REQ-037 Reset mid-message or mid-emit SHALL discard all partial data with no block emitted.

Verification
REQ-038 IN_BYTES=1, bytes 0x68, 0x69 (last) -> one block: [511:480]=0x68698000, [63:0]=0x10, block_last=1, other bits 0.
REQ-039 Empty message (one beat, last, nbytes=0) -> one block: [511:504]=0x80, all else 0, block_last=1.
REQ-040 55 bytes -> one block: 0x80 at byte 55, [63:0]=0x1B8; 56 bytes -> two blocks: first with 0x80 at byte 56 and last=0, second all-zero except [63:0]=0x1C0 and last=1.
REQ-041 64 bytes with IN_BYTES=4 -> data block (last=0), then block with 0x80 at byte 0 and [63:0]=0x200 (last=1); data_ready=0 throughout both emits.
REQ-042 block_ready held low 5 cycles during EMIT_DATA -> block_out unchanged and data_ready=0 for all 5 cycles; the next message starts correctly.
REQ-043 rst_n pulsed low after 30 bytes, then message "hi" -> only the REQ-038 block appears, with length 0x10.
